fifo_frame_packer: RTL and testbench



---
 rtl/fifo_frame_packer.sv | 124 ++++++++++++
 tb/tb_fifo_frame_packer.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_frame_packer.sv
// ============================================================================
// fifo_frame_packer
// Drains payload words from a FIFO read port and frames them as header,
// FRAME_LEN payload words and a modular-sum checksum on a valid/ready stream.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fifo_frame_packer #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    FRAME_LEN  = 4,
  parameter logic [DATA_WIDTH-1:0] HDR_WORD   = 'hA5,
  parameter int                    CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_rd_en,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  frame_done,
  output logic [CNT_WIDTH-1:0]  frame_count
);

  localparam logic [7:0] C_LAST_IDX = 8'(FRAME_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR   = 3'd1,
    S_FETCH = 3'd2,
    S_LOAD  = 3'd3,
    S_SEND  = 3'd4,
    S_CSUM  = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic [7:0]            idx_q, idx_d;
  logic [DATA_WIDTH-1:0] csum_q, csum_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      csum_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      csum_q  <= csum_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  // Stream outputs depend only on registered state; rd_en and frame_done are
  // the only combinational strobes.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    csum_d     = csum_q;
    data_d     = data_q;
    cnt_d      = cnt_q;
    fifo_rd_en = 1'b0;
    out_valid  = 1'b0;
    out_data   = '0;
    out_last   = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) state_d = S_HDR;
      end
      S_HDR: begin
        out_valid = 1'b1;
        out_data  = HDR_WORD;
        if (out_ready) state_d = S_FETCH;
      end
      S_FETCH: begin
        fifo_rd_en = !fifo_empty;
        if (!fifo_empty) state_d = S_LOAD;
      end
      S_LOAD: begin
        data_d  = fifo_dout;
        csum_d  = csum_q + fifo_dout;
        state_d = S_SEND;
      end
      S_SEND: begin
        out_valid = 1'b1;
        out_data  = data_q;
        if (out_ready) begin
          if (idx_q == C_LAST_IDX) begin
            state_d = S_CSUM;
          end else begin
            idx_d   = idx_q + 8'd1;
            state_d = S_FETCH;
          end
        end
      end
      S_CSUM: begin
        out_valid = 1'b1;
        out_data  = csum_q;
        out_last  = 1'b1;
        if (out_ready) begin
          frame_done = 1'b1;
          cnt_d      = cnt_q + 1'b1;
          csum_d     = '0;
          idx_d      = '0;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign frame_count = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_fifo_frame_packer.sv
// Scoreboard bench for fifo_frame_packer with a behavioural FIFO read port.
`default_nettype none

module tb_fifo_frame_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fifo_empty;
  logic [7:0]  fifo_dout = 8'h00;
  logic        fifo_rd_en;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  out_data;
  logic        out_last;
  logic        frame_done;
  logic [15:0] frame_count;

  int n_checks = 0;
  int n_fail   = 0;
  int n_acc    = 0;
  int n_done   = 0;

  logic [8:0] exp_q[$];

  logic [7:0] mem[0:255];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int rd_cnt = 0;
  int rd_bad = 0;

  fifo_frame_packer #(
    .DATA_WIDTH(8),
    .FRAME_LEN (4),
    .HDR_WORD  (8'hA5),
    .CNT_WIDTH (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_rd_en (fifo_rd_en),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .frame_done (frame_done),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      rd_cnt <= rd_cnt + 1;
      if (fifo_empty) begin
        rd_bad <= rd_bad + 1;
      end else begin
        fifo_dout <= mem[rd_ptr % 256];
        rd_ptr    <= rd_ptr + 1;
      end
    end
  end

  // Output monitor: every accepted word is checked against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_done) n_done = n_done + 1;
      if (out_valid && out_ready) begin
        logic [8:0] e;
        n_acc    = n_acc + 1;
        n_checks = n_checks + 1;
        if (exp_q.size() == 0) begin
          n_fail = n_fail + 1;
          $display("FAIL unexpected_word: got data=%02h last=%0b, none expected", out_data, out_last);
        end else begin
          e = exp_q.pop_front();
          if ({out_last, out_data} !== e) begin
            n_fail = n_fail + 1;
            $display("FAIL stream_word: got last=%0b data=%02h, expected last=%0b data=%02h",
                     out_last, out_data, e[8], e[7:0]);
          end
        end
        n_checks = n_checks + 1;
        if (frame_done !== out_last) begin
          n_fail = n_fail + 1;
          $display("FAIL frame_done_on_accept: got %0b, expected %0b", frame_done, out_last);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fifo_push(input logic [7:0] b);
    mem[wr_ptr % 256] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  // Queue the full expected frame; load only the first nload payload words.
  task automatic send_frame(input logic [7:0] b0, b1, b2, b3, input int nload);
    logic [7:0] s;
    s = b0 + b1 + b2 + b3;
    exp_q.push_back({1'b0, 8'hA5});
    exp_q.push_back({1'b0, b0});
    exp_q.push_back({1'b0, b1});
    exp_q.push_back({1'b0, b2});
    exp_q.push_back({1'b0, b3});
    exp_q.push_back({1'b1, s});
    if (nload > 0) fifo_push(b0);
    if (nload > 1) fifo_push(b1);
    if (nload > 2) fifo_push(b2);
    if (nload > 3) fifo_push(b3);
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      tick();
      k++;
    end
    n_checks = n_checks + 1;
    if (exp_q.size() != 0) begin
      n_fail = n_fail + 1;
      $display("FAIL drain_timeout: %0d words outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (3) tick();
  endtask

  task automatic wait_accepts(input int target, input int budget);
    int k = 0;
    while (n_acc < target && k < budget) begin
      tick();
      k++;
    end
    n_checks = n_checks + 1;
    if (n_acc < target) begin
      n_fail = n_fail + 1;
      $display("FAIL accept_timeout: accepted %0d, expected %0d", n_acc, target);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    n_checks = n_checks + 1;
    if ({fifo_rd_en, out_valid, out_data, out_last, frame_done} !== 12'h000 || frame_count !== 16'd0) begin
      n_fail = n_fail + 1;
      $display("FAIL reset_values: got rd=%0b v=%0b d=%02h l=%0b fd=%0b fc=%0d, expected all 0",
               fifo_rd_en, out_valid, out_data, out_last, frame_done, frame_count);
    end
    rst = 1'b0;
    repeat (2) tick();
    n_checks = n_checks + 1;
    if (out_valid !== 1'b0) begin
      n_fail = n_fail + 1;
      $display("FAIL idle_when_empty: out_valid=%0b, expected 0", out_valid);
    end
  endtask

  task automatic test_basic();
    int r0, d0;
    r0 = rd_cnt;
    d0 = n_done;
    send_frame(8'h01, 8'h02, 8'h03, 8'h04, 4);
    wait_drain(200);
    n_checks = n_checks + 1;
    if (rd_cnt - r0 !== 4) begin
      n_fail = n_fail + 1;
      $display("FAIL basic_rd_count: got %0d, expected 4", rd_cnt - r0);
    end
    n_checks = n_checks + 1;
    if (n_done - d0 !== 1) begin
      n_fail = n_fail + 1;
      $display("FAIL basic_done_pulses: got %0d, expected 1", n_done - d0);
    end
    n_checks = n_checks + 1;
    if (frame_count !== 16'd1) begin
      n_fail = n_fail + 1;
      $display("FAIL basic_frame_count: got %0d, expected 1", frame_count);
    end
  endtask

  task automatic test_checksum_wrap();
    send_frame(8'hFF, 8'hFF, 8'hFF, 8'h03, 4);
    wait_drain(200);
    n_checks = n_checks + 1;
    if (frame_count !== 16'd2) begin
      n_fail = n_fail + 1;
      $display("FAIL wrap_frame_count: got %0d, expected 2", frame_count);
    end
  endtask

  task automatic test_backpressure();
    int k = 0;
    int r1;
    send_frame(8'h01, 8'h02, 8'h03, 8'h04, 4);
    while (!(out_valid && out_data == 8'h02) && k < 100) begin
      tick();
      k++;
    end
    out_ready = 1'b0;
    r1 = rd_cnt;
    for (int i = 0; i < 5; i++) begin
      n_checks = n_checks + 1;
      if (out_valid !== 1'b1 || out_data !== 8'h02 || out_last !== 1'b0) begin
        n_fail = n_fail + 1;
        $display("FAIL bp_hold cycle %0d: got v=%0b d=%02h l=%0b, expected v=1 d=02 l=0",
                 i, out_valid, out_data, out_last);
      end
      tick();
    end
    n_checks = n_checks + 1;
    if (rd_cnt !== r1) begin
      n_fail = n_fail + 1;
      $display("FAIL bp_no_read: got %0d reads during stall, expected 0", rd_cnt - r1);
    end
    out_ready = 1'b1;
    wait_drain(200);
  endtask

  task automatic test_underflow();
    send_frame(8'h01, 8'h02, 8'h03, 8'h04, 2);
    wait_accepts(n_acc + 3, 100);
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks = n_checks + 1;
      if (fifo_rd_en !== 1'b0 || out_valid !== 1'b0) begin
        n_fail = n_fail + 1;
        $display("FAIL underflow_stall cycle %0d: got rd=%0b v=%0b, expected 0 0", i, fifo_rd_en, out_valid);
      end
    end
    fifo_push(8'h03);
    fifo_push(8'h04);
    wait_drain(200);
    n_checks = n_checks + 1;
    if (frame_count !== 16'd4) begin
      n_fail = n_fail + 1;
      $display("FAIL underflow_frame_count: got %0d, expected 4", frame_count);
    end
  endtask

  task automatic test_back_to_back();
    int d0;
    d0 = n_done;
    send_frame(8'h10, 8'h11, 8'h12, 8'h13, 4);
    send_frame(8'h14, 8'h15, 8'h16, 8'h17, 4);
    wait_drain(400);
    n_checks = n_checks + 1;
    if (n_done - d0 !== 2) begin
      n_fail = n_fail + 1;
      $display("FAIL b2b_done_pulses: got %0d, expected 2", n_done - d0);
    end
    n_checks = n_checks + 1;
    if (frame_count !== 16'd6) begin
      n_fail = n_fail + 1;
      $display("FAIL b2b_frame_count: got %0d, expected 6", frame_count);
    end
  endtask

  task automatic test_reset_midframe();
    exp_q.push_back({1'b0, 8'hA5});
    exp_q.push_back({1'b0, 8'h20});
    exp_q.push_back({1'b0, 8'h21});
    fifo_push(8'h20);
    fifo_push(8'h21);
    wait_accepts(n_acc + 3, 100);
    tick();
    rst = 1'b1;
    #1;
    n_checks = n_checks + 1;
    if ({fifo_rd_en, out_valid, out_data, out_last, frame_done} !== 12'h000 || frame_count !== 16'd0) begin
      n_fail = n_fail + 1;
      $display("FAIL midframe_reset: got rd=%0b v=%0b d=%02h l=%0b fd=%0b fc=%0d, expected all 0",
               fifo_rd_en, out_valid, out_data, out_last, frame_done, frame_count);
    end
    tick();
    rst = 1'b0;
    tick();
    send_frame(8'h30, 8'h31, 8'h32, 8'h33, 4);
    wait_drain(200);
    n_checks = n_checks + 1;
    if (frame_count !== 16'd1) begin
      n_fail = n_fail + 1;
      $display("FAIL post_reset_frame_count: got %0d, expected 1", frame_count);
    end
    n_checks = n_checks + 1;
    if (rd_bad !== 0) begin
      n_fail = n_fail + 1;
      $display("FAIL read_while_empty: got %0d, expected 0", rd_bad);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_checksum_wrap();
    test_backpressure();
    test_underflow();
    test_back_to_back();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
